calc_entry: RTL and testbench

- Sits directly downstream of the keypad scanner and consumes its decoded key outputs (key_press, is_num, is_op, is_eq, num_val, op_val).
- Converts each key press into exactly one key event.
- Accumulates decimal operands, latches the operator and evaluates add/subtract on '=' or on a chained operator.
- Presents a signed binary value for the display stage along with result and error flags.

---
 rtl/calc_entry.sv | 187 ++++++++++++++++++
 tb/tb_calc_entry.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry.sv
// calc_entry: turns decoded keypad keys into operand entry, add/subtract
// evaluation and a signed display value for the display stage.
//
// state | meaning
// ------+--------------------------------------------------------------
// S_A   | entering the first operand (a), or a result being reused as a
// S_OP  | operator latched, waiting for the first digit of b
// S_B   | entering the second operand (b); display shows b
// S_RES | result of '=' held in a; digit starts over, operator chains
module calc_entry #(
    parameter int DIGITS = 4,
    parameter int MAXV   = 9999,
    parameter int RW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_press,
    input  logic          is_num,
    input  logic          is_op,
    input  logic          is_eq,
    input  logic [3:0]    num_val,
    input  logic [1:0]    op_val,
    output logic [RW-1:0] disp_val,
    output logic [1:0]    state,
    output logic          result_valid,
    output logic          ovf,
    output logic          err
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_OP  = 2'd1,
        S_B   = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic signed [RW:0]   POS_LIM = (RW+1)'(MAXV);
    localparam logic signed [RW:0]   NEG_LIM = -POS_LIM;
    localparam logic signed [RW-1:0] POS_SAT = RW'(MAXV);
    localparam logic signed [RW-1:0] NEG_SAT = -POS_SAT;

    state_t                st_q, st_d;
    logic signed [RW-1:0]  a_q, a_d;
    logic signed [RW-1:0]  b_q, b_d;
    logic                  op_sub_q, op_sub_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  kp_d_q;
    logic                  ovf_q, ovf_d;
    logic                  rv_q, rv_d;
    logic                  err_q, err_d;

    logic                  evt;
    logic                  op_bad;
    logic                  cnt_full;
    logic                  dig_adv;
    logic signed [RW-1:0]  num_ext;
    logic signed [RW-1:0]  acc_src;
    logic signed [RW-1:0]  acc_nx;
    logic signed [RW:0]    ext_a, ext_b, sum;
    logic signed [RW-1:0]  ev_val;
    logic                  ev_sat;

    // Key-level delay line; held at 1 in reset so a key held across reset release is not an event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) kp_d_q <= 1'b1;
        else      kp_d_q <= key_press;
    end

    assign evt = key_press & ~kp_d_q;

    // Arithmetic helpers: digit accumulate and saturating add/subtract of a and b
    always_comb begin
        op_bad   = (op_val == 2'd0) || (op_val == 2'd3);
        num_ext  = {{(RW-4){1'b0}}, num_val};
        acc_src  = (st_q == S_B) ? b_q : a_q;
        acc_nx   = (acc_src <<< 3) + (acc_src <<< 1) + num_ext;
        cnt_full = (cnt_q == CW'(DIGITS));
        dig_adv  = (acc_src != '0) || (num_val != 4'd0);

        ext_a  = {a_q[RW-1], a_q};
        ext_b  = {b_q[RW-1], b_q};
        sum    = op_sub_q ? (ext_a - ext_b) : (ext_a + ext_b);
        ev_val = sum[RW-1:0];
        ev_sat = 1'b0;
        if (sum > POS_LIM) begin
            ev_val = POS_SAT;
            ev_sat = 1'b1;
        end else if (sum < NEG_LIM) begin
            ev_val = NEG_SAT;
            ev_sat = 1'b1;
        end
    end

    // Next-state and register updates; only an event cycle changes anything
    always_comb begin
        st_d     = st_q;
        a_d      = a_q;
        b_d      = b_q;
        op_sub_d = op_sub_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        if (evt) begin
            if (is_eq) begin
                if (st_q == S_B) begin
                    a_d   = ev_val;
                    ovf_d = ovf_q | ev_sat;
                    rv_d  = 1'b1;
                    st_d  = S_RES;
                end
            end else if (is_op) begin
                if (op_bad) begin
                    err_d = 1'b1;
                end else begin
                    if (st_q == S_B) begin
                        a_d   = ev_val;
                        ovf_d = ovf_q | ev_sat;
                    end
                    op_sub_d = (op_val == 2'd2);
                    st_d     = S_OP;
                end
            end else if (is_num) begin
                if (num_val > 4'd9) begin
                    err_d = 1'b1;
                end else begin
                    case (st_q)
                        S_A: begin
                            if (!cnt_full) begin
                                a_d = acc_nx;
                                if (dig_adv) cnt_d = cnt_q + CW'(1);
                            end
                        end
                        S_OP: begin
                            b_d   = num_ext;
                            cnt_d = CW'(num_val != 4'd0);
                            st_d  = S_B;
                        end
                        S_B: begin
                            if (!cnt_full) begin
                                b_d = acc_nx;
                                if (dig_adv) cnt_d = cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            a_d   = num_ext;
                            cnt_d = CW'(num_val != 4'd0);
                            ovf_d = 1'b0;
                            st_d  = S_A;
                        end
                    endcase
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_sub_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_sub_q <= op_sub_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign disp_val     = (st_q == S_B) ? b_q : a_q;
    assign state        = st_q;
    assign result_valid = rv_q;
    assign ovf          = ovf_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_entry.sv
// Bench for calc_entry: an integer-arithmetic calculator model checked every
// cycle, plus hand-computed literal expectations along the directed sequences.
module tb_calc_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_press = 1'b0;
    logic        is_num = 1'b0;
    logic        is_op = 1'b0;
    logic        is_eq = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic [15:0] disp_val;
    logic [1:0]  state;
    logic        result_valid;
    logic        ovf;
    logic        err;

    int total = 0;
    int bad = 0;
    int rv_cnt = 0;
    int err_cnt = 0;

    // model state: plain integers, state numbers as seen on the port
    int ma, mb, mst, mop, movf, mrv, merr, kp_prev;

    calc_entry #(.DIGITS(4), .MAXV(9999), .RW(16)) dut (
        .clk(clk), .rst(rst), .key_press(key_press), .is_num(is_num),
        .is_op(is_op), .is_eq(is_eq), .num_val(num_val), .op_val(op_val),
        .disp_val(disp_val), .state(state), .result_valid(result_valid),
        .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int ndig(input int v);
        int n = 0;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    function automatic int sat(input int v);
        if (v > 9999) return 9999;
        if (v < -9999) return -9999;
        return v;
    endfunction

    task automatic mreset();
        ma = 0; mb = 0; mst = 0; mop = 1; movf = 0; mrv = 0; merr = 0; kp_prev = 1;
    endtask

    task automatic mevaluate();
        int r;
        r = (mop == 2) ? ma - mb : ma + mb;
        if (sat(r) != r) movf = 1;
        ma = sat(r);
    endtask

    task automatic mevent();
        if (is_eq) begin
            if (mst == 2) begin
                mevaluate();
                mrv = 1;
                mst = 3;
            end
        end else if (is_op) begin
            if (op_val == 0 || op_val == 3) merr = 1;
            else begin
                if (mst == 2) mevaluate();
                mop = int'(op_val);
                mst = 1;
            end
        end else if (is_num) begin
            if (num_val > 9) merr = 1;
            else begin
                case (mst)
                    0: if (ndig(ma) < 4) ma = ma * 10 + int'(num_val);
                    1: begin mb = int'(num_val); mst = 2; end
                    2: if (ndig(mb) < 4) mb = mb * 10 + int'(num_val);
                    default: begin ma = int'(num_val); movf = 0; mst = 0; end
                endcase
            end
        end
    endtask

    // model: one event per rising key level, evaluated at the clock edge
    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) mreset();
            else begin
                mrv = 0;
                merr = 0;
                if (key_press && kp_prev == 0) mevent();
                kp_prev = key_press ? 1 : 0;
            end
        end
    end

    // per-cycle comparison against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cmp("disp_val", int'($signed(disp_val)), (mst == 2) ? mb : ma);
            cmp("state", int'(state), mst);
            cmp("result_valid", int'(result_valid), mrv);
            cmp("ovf", int'(ovf), movf);
            cmp("err", int'(err), merr);
            if (result_valid) rv_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic press(input bit n, input bit o, input bit e, input int nv, input int ov, input int hold);
        @(posedge clk); #2;
        is_num = n; is_op = o; is_eq = e;
        num_val = 4'(nv); op_val = 2'(ov);
        key_press = 1'b1;
        repeat (hold) @(posedge clk);
        #2;
        key_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic dig(input int v);  press(1, 0, 0, v, 0, 2); endtask
    task automatic opk(input int v);  press(0, 1, 0, 0, v, 2); endtask
    task automatic eqk();             press(0, 0, 1, 0, 0, 2); endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int rv0, err0;
        repeat (3) @(posedge clk);
        #2;
        cmp("lit_reset_disp", int'(disp_val), 0);
        cmp("lit_reset_state", int'(state), 0);
        rst = 1'b1;

        // 12 + 34 = 46
        rv0 = rv_cnt;
        dig(1); dig(2);
        cmp("lit_a12", int'($signed(disp_val)), 12);
        opk(1); dig(3); dig(4);
        cmp("lit_b34", int'($signed(disp_val)), 34);
        cmp("lit_state_b", int'(state), 2);
        eqk();
        cmp("lit_res46", int'($signed(disp_val)), 46);
        cmp("lit_state_res", int'(state), 3);
        cmp("lit_rv_once", rv_cnt - rv0, 1);

        // 5 - 9 = -4
        dig(5); opk(2); dig(9); eqk();
        cmp("lit_neg4", int'(disp_val), 16'hFFFC);
        cmp("lit_ovf0", int'(ovf), 0);

        // 9999 (fifth 9 dropped) + 1 saturates
        repeat (5) dig(9);
        cmp("lit_a9999", int'($signed(disp_val)), 9999);
        opk(1); dig(1); eqk();
        cmp("lit_sat", int'($signed(disp_val)), 9999);
        cmp("lit_ovf1", int'(ovf), 1);
        dig(3);
        cmp("lit_ovf_clr", int'(ovf), 0);
        cmp("lit_new_a3", int'($signed(disp_val)), 3);
        cmp("lit_state_a", int'(state), 0);

        // leading zeros are free: 0,0,1,2,3,4 -> 1234 then 5 dropped
        do_reset();
        dig(0); dig(0); dig(1); dig(2); dig(3); dig(4); dig(5);
        cmp("lit_lead0", int'($signed(disp_val)), 1234);

        // chain 2 + 3 - 1 = 4
        do_reset();
        rv0 = rv_cnt;
        dig(2); opk(1); dig(3); opk(2);
        cmp("lit_chain5", int'($signed(disp_val)), 5);
        cmp("lit_chain_op", int'(state), 1);
        cmp("lit_chain_norv", rv_cnt - rv0, 0);
        dig(1); eqk();
        cmp("lit_chain4", int'($signed(disp_val)), 4);
        cmp("lit_chain_rv", rv_cnt - rv0, 1);
        eqk();
        cmp("lit_no_repeat", rv_cnt - rv0, 1);

        // held key, invalid keys, priority
        press(1, 0, 0, 7, 0, 20);
        cmp("lit_held7", int'($signed(disp_val)), 7);
        err0 = err_cnt;
        opk(3);
        cmp("lit_err_op3", err_cnt - err0, 1);
        cmp("lit_err_state", int'(state), 0);
        dig(12);
        cmp("lit_err_num", err_cnt - err0, 2);
        eqk();
        cmp("lit_eq_in_a", int'(state), 0);
        press(1, 1, 0, 5, 1, 2);
        cmp("lit_prio_op", int'(state), 1);
        press(1, 0, 1, 5, 0, 2);
        cmp("lit_prio_eq_ign", int'(state), 1);
        dig(2);
        press(1, 1, 1, 6, 2, 2);
        cmp("lit_prio_eq", int'($signed(disp_val)), 9);
        cmp("lit_prio_eq_st", int'(state), 3);

        // reset in the middle of entry with a key held through release
        do_reset();
        dig(1); opk(1); dig(3);
        cmp("lit_mid_b3", int'($signed(disp_val)), 3);
        rv0 = rv_cnt;
        @(posedge clk); #2;
        rst = 1'b0; key_press = 1'b1; is_num = 1'b1; num_val = 4'd5;
        @(posedge clk); #2;
        cmp("lit_rst_disp", int'(disp_val), 0);
        cmp("lit_rst_state", int'(state), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        cmp("lit_held_noevt", int'(disp_val), 0);
        cmp("lit_rst_norv", rv_cnt - rv0, 0);
        key_press = 1'b0; is_num = 1'b0;
        @(posedge clk); #2;
        dig(5);
        cmp("lit_after_rst5", int'($signed(disp_val)), 5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
